// File: rtl/cim_mmio_bridge_if.sv
// CPU data-bus bundle between the darkriscv data port and the CIM bridge.
// The CPU drives address, data and strobes; the bridge returns registered read data and HIT.
interface cim_mmio_bridge_if;
    logic [31:0] DADDR;
    logic [31:0] DATAO;
    logic        WR;
    logic        RD;
    logic [3:0]  BE;
    logic [31:0] DATAI;
    logic        HIT;

    modport master (
        output DADDR, DATAO, WR, RD, BE,
        input  DATAI, HIT
    );

    modport slave (
        input  DADDR, DATAO, WR, RD, BE,
        output DATAI, HIT
    );
endinterface

// File: rtl/cim_mmio_bridge.sv
// Memory-mapped bridge turning CPU loads/stores into Basic_GeMM_CIM command pulses,
// with a small sequencer that waits out the CIM latency and captures the result.
module cim_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CIM_LAT   = 2
) (
    input  logic                    CLK,
    input  logic                    RES,
    cim_mmio_bridge_if.slave        cpu,
    output logic                    IRQ,
    output logic                    write,
    output logic                    cim,
    output logic                    partial_sum,
    output logic                    reset_output,
    output logic [3:0]              output_reg,
    output logic [31:0]             address,
    output logic [31:0]             input_data,
    input  logic [31:0]             cim_output
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_CIM = 2'd1;
    localparam logic [1:0] OP_RD  = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    localparam logic [2:0] OFF_CMD    = 3'd0;
    localparam logic [2:0] OFF_ADDR   = 3'd1;
    localparam logic [2:0] OFF_DATA   = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_RESULT = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    localparam logic [3:0] LAT_M1 = 4'(CIM_LAT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [1:0]  r_op;
    logic        r_ps;
    logic [3:0]  r_oreg;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_ainc;
    logic        r_ie;
    logic [31:0] r_result;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_datai;
    logic        r_hit;

    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_bmask;
    logic        w_cmd_wr;
    logic        w_accept;
    logic        w_drop;
    logic        w_busy;
    logic        w_inc;
    logic        w_capt;
    logic [31:0] w_addr_base;
    logic [31:0] w_addr_next;
    logic [31:0] w_data_next;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Window is 32 bytes, so only DADDR[31:5] takes part in the decode.
    assign w_sel    = (cpu.DADDR[31:5] == BASE_ADDR[31:5]);
    assign w_off    = cpu.DADDR[4:2];
    assign w_wr     = cpu.WR & w_sel;
    assign w_rd     = cpu.RD & w_sel;
    assign w_unused = &{1'b0, cpu.DADDR[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bmask
            assign w_bmask[gi*8 +: 8] = {8{cpu.BE[gi]}};
        end
    endgenerate

    assign w_cmd_wr = w_wr && (w_off == OFF_CMD) && cpu.BE[0];
    assign w_accept = w_cmd_wr && (r_state == S_IDLE);
    assign w_drop   = w_cmd_wr && (r_state != S_IDLE);
    assign w_busy   = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_inc        = 1'b0;
        w_capt       = 1'b0;
        write        = 1'b0;
        cim          = 1'b0;
        partial_sum  = 1'b0;
        reset_output = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (r_op)
                    OP_WR: begin
                        write        = 1'b1;
                        w_inc        = r_ainc;
                        w_state_next = S_IDLE;
                    end
                    OP_CIM: begin
                        cim          = 1'b1;
                        partial_sum  = r_ps;
                        w_cnt_next   = LAT_M1;
                        w_state_next = S_WAIT;
                    end
                    OP_RD: begin
                        w_cnt_next   = LAT_M1;
                        w_state_next = S_WAIT;
                    end
                    OP_CLR: begin
                        reset_output = 1'b1;
                        w_state_next = S_IDLE;
                    end
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_CAPT;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_CAPT: begin
                w_capt       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A CPU store to ADDR on the auto-increment edge overrides the enabled bytes.
    always_comb begin
        w_addr_base = w_inc ? (r_addr + 32'd1) : r_addr;
        w_addr_next = w_addr_base;
        w_data_next = r_data;
        if (w_wr && (w_off == OFF_ADDR)) begin
            w_addr_next = (w_addr_base & ~w_bmask) | (cpu.DATAO & w_bmask);
        end
        if (w_wr && (w_off == OFF_DATA)) begin
            w_data_next = (r_data & ~w_bmask) | (cpu.DATAO & w_bmask);
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_ADDR:   w_rdata = r_addr;
            OFF_DATA:   w_rdata = r_data;
            OFF_CTRL:   w_rdata = {30'd0, r_ie, r_ainc};
            OFF_RESULT: w_rdata = r_result;
            OFF_STATUS: w_rdata = {29'd0, r_err, r_valid, w_busy};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_op     <= 2'd0;
            r_ps     <= 1'b0;
            r_oreg   <= 4'd0;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_ainc   <= 1'b0;
            r_ie     <= 1'b0;
            r_result <= 32'd0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_datai  <= 32'd0;
            r_hit    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            if (w_accept) begin
                r_op   <= cpu.DATAO[1:0];
                r_ps   <= cpu.DATAO[2];
                r_oreg <= cpu.DATAO[7:4];
            end
            if (w_wr && (w_off == OFF_CTRL) && cpu.BE[0]) begin
                r_ainc <= cpu.DATAO[0];
                r_ie   <= cpu.DATAO[1];
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && cpu.BE[0] && cpu.DATAO[2]) begin
                r_err <= 1'b0;
            end
            if (w_capt) begin
                r_result <= cim_output;
            end
            // Capture beats a same-cycle RESULT read, so a fresh result is never lost.
            if (w_capt) begin
                r_valid <= 1'b1;
            end else if (w_rd && (w_off == OFF_RESULT)) begin
                r_valid <= 1'b0;
            end
            r_hit   <= w_rd;
            r_datai <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign cpu.DATAI  = r_datai;
    assign cpu.HIT    = r_hit;
    assign IRQ        = r_valid & r_ie;
    assign address    = r_addr;
    assign input_data = r_data;
    assign output_reg = r_oreg;

endmodule

// File: tb/tb_cim_mmio_bridge.sv
// Scoreboard bench for cim_mmio_bridge: expected read data and CIM pulses are queued
// when stimulus is driven and checked when the bridge produces them.
module tb_cim_mmio_bridge;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int          CIM_LAT = 2;
    localparam logic [31:0] A_CMD   = BASE + 32'h00;
    localparam logic [31:0] A_ADDR  = BASE + 32'h04;
    localparam logic [31:0] A_DATA  = BASE + 32'h08;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0C;
    localparam logic [31:0] A_RES   = BASE + 32'h10;
    localparam logic [31:0] A_STAT  = BASE + 32'h14;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ps;
        logic [3:0]  oreg;
    } pulse_t;

    logic        CLK = 1'b0;
    logic        RES;
    logic        IRQ;
    logic        write;
    logic        cim;
    logic        partial_sum;
    logic        reset_output;
    logic [3:0]  output_reg;
    logic [31:0] address;
    logic [31:0] input_data;
    logic [31:0] cim_output = 32'd0;

    cim_mmio_bridge_if bus ();

    cim_mmio_bridge #(.BASE_ADDR(BASE), .CIM_LAT(CIM_LAT)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .cpu          (bus),
        .IRQ          (IRQ),
        .write        (write),
        .cim          (cim),
        .partial_sum  (partial_sum),
        .reset_output (reset_output),
        .output_reg   (output_reg),
        .address      (address),
        .input_data   (input_data),
        .cim_output   (cim_output)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_q[$];
    pulse_t      pulse_q[$];
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] model_val = 32'd0;
    int          lat_q = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // CIM array model: garbage right after a compute pulse, result valid CIM_LAT cycles later.
    always @(posedge CLK) begin
        if (cim) begin
            lat_q      <= CIM_LAT - 1;
            cim_output <= 32'hDEAD_BEEF;
        end else if (lat_q > 1) begin
            lat_q <= lat_q - 1;
        end else begin
            lat_q      <= 0;
            cim_output <= model_val;
        end
    end

    always @(negedge CLK) begin
        int     n_act;
        pulse_t p;
        logic [1:0] k;
        if (RES === 1'b0) begin
            n_act = int'(write) + int'(cim) + int'(reset_output);
            if (n_act != 0) begin
                chk("pulse_onehot", n_act, 1);
                if (pulse_q.size() == 0) begin
                    chk("pulse_unexpected", n_act, 0);
                end else begin
                    p = pulse_q.pop_front();
                    k = write ? 2'd0 : (cim ? 2'd1 : 2'd3);
                    $display("[TB] pulse kind=%0d addr=%h data=%h ps=%0b oreg=%0d",
                             k, address, input_data, partial_sum, output_reg);
                    chk("pulse_kind", {30'd0, k}, {30'd0, p.kind});
                    chk("pulse_addr", address, p.addr);
                    chk("pulse_data", input_data, p.data);
                    chk("pulse_ps", {31'd0, partial_sum}, {31'd0, p.ps});
                    chk("pulse_oreg", {28'd0, output_reg}, {28'd0, p.oreg});
                end
            end else begin
                chk("ps_idle", {31'd0, partial_sum}, 32'd0);
            end
            if (bus.HIT === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", {31'd0, bus.HIT}, 32'd0);
                end else begin
                    chk("rd_data", bus.DATAI, rd_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        $display("[TB] wr addr=%h data=%h be=%b", a, d, be);
        bus.DADDR = a;
        bus.DATAO = d;
        bus.BE    = be;
        bus.WR    = 1'b1;
        @(posedge CLK);
        #1;
        bus.WR = 1'b0;
        bus.BE = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        $display("[TB] rd addr=%h expect=%h", a, exp);
        rd_q.push_back(exp);
        bus.DADDR = a;
        bus.RD    = 1'b1;
        @(posedge CLK);
        #1;
        bus.RD = 1'b0;
    endtask

    task automatic rd_oow(input logic [31:0] a);
        $display("[TB] rd out-of-window addr=%h", a);
        bus.DADDR = a;
        bus.RD    = 1'b1;
        @(posedge CLK);
        #1;
        bus.RD = 1'b0;
        chk("oow_hit", {31'd0, bus.HIT}, 32'd0);
        chk("oow_datai", bus.DATAI, 32'd0);
    endtask

    task automatic cmd(input logic [7:0] c);
        wr(A_CMD, {24'd0, c}, 4'hF);
    endtask

    task automatic push_pulse(input logic [1:0] kind, input logic ps, input logic [3:0] oreg);
        pulse_t p;
        p.kind = kind;
        p.addr = m_addr;
        p.data = m_data;
        p.ps   = ps;
        p.oreg = oreg;
        pulse_q.push_back(p);
    endtask

    task automatic chk_cim_idle(input string tag);
        chk({tag, "_write"}, {31'd0, write}, 32'd0);
        chk({tag, "_cim"}, {31'd0, cim}, 32'd0);
        chk({tag, "_ps"}, {31'd0, partial_sum}, 32'd0);
        chk({tag, "_rstout"}, {31'd0, reset_output}, 32'd0);
        chk({tag, "_oreg"}, {28'd0, output_reg}, 32'd0);
        chk({tag, "_address"}, address, 32'd0);
        chk({tag, "_indata"}, input_data, 32'd0);
        chk({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RES       = 1'b1;
        bus.DADDR = 32'd0;
        bus.DATAO = 32'd0;
        bus.WR    = 1'b0;
        bus.RD    = 1'b0;
        bus.BE    = 4'd0;
        tick(3);
        chk("rst_datai", bus.DATAI, 32'd0);
        chk("rst_hit", {31'd0, bus.HIT}, 32'd0);
        chk_cim_idle("rst");
        RES = 1'b0;
        rd(A_STAT, 32'd0);
        rd(A_RES, 32'd0);
        rd(A_CTRL, 32'd0);
        rd(A_CMD, 32'd0);

        // Weight write: one write pulse, busy for exactly the ISSUE cycle.
        wr(A_ADDR, 32'd5, 4'hF);            m_addr = 32'd5;
        wr(A_DATA, 32'hA5A5_0F0F, 4'hF);    m_data = 32'hA5A5_0F0F;
        push_pulse(2'd0, 1'b0, 4'd0);
        cmd(8'h00);
        rd(A_STAT, 32'd1);
        rd(A_STAT, 32'd0);
        rd(A_ADDR, 32'd5);

        // Compute with ps=1, oreg=3; result captured after the latency.
        wr(A_CTRL, 32'd2, 4'hF);
        model_val = 32'h0000_1234;
        push_pulse(2'd1, 1'b1, 4'd3);
        cmd(8'h35);
        tick(3);
        chk("irq_before_capt", {31'd0, IRQ}, 32'd0);
        tick(1);
        chk("irq_after_capt", {31'd0, IRQ}, 32'd1);
        chk("oreg_compute", {28'd0, output_reg}, 32'd3);
        rd(A_STAT, 32'd2);
        rd(A_RES, 32'h0000_1234);
        rd(A_STAT, 32'd0);
        chk("irq_cleared", {31'd0, IRQ}, 32'd0);

        // RESULT read on the capture edge returns the old value; valid stays set.
        model_val = 32'h0000_CAFE;
        push_pulse(2'd1, 1'b0, 4'd0);
        cmd(8'h01);
        tick(3);
        rd(A_RES, 32'h0000_1234);
        rd(A_STAT, 32'd2);
        rd(A_RES, 32'h0000_CAFE);
        rd(A_STAT, 32'd0);

        // Readout: no pulse, output_reg selects, result captured.
        model_val = 32'hBEEF_0001;
        cmd(8'h52);
        tick(1);
        chk("oreg_readout", {28'd0, output_reg}, 32'd5);
        tick(3);
        rd(A_STAT, 32'd2);
        rd(A_RES, 32'hBEEF_0001);

        // Clear.
        push_pulse(2'd3, 1'b0, 4'd0);
        cmd(8'h03);
        tick(1);
        chk("oreg_clear", {28'd0, output_reg}, 32'd0);

        // Auto-increment over four weight writes.
        wr(A_CTRL, 32'd3, 4'hF);
        wr(A_ADDR, 32'd0, 4'hF);            m_addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            push_pulse(2'd0, 1'b0, 4'd0);
            cmd(8'h00);
            m_addr = m_addr + 32'd1;
            tick(1);
        end
        rd(A_ADDR, 32'd4);
        rd(A_STAT, 32'd0);
        wr(A_CTRL, 32'd2, 4'hF);

        // Command while busy is dropped and flags err; W1C clears it.
        model_val = 32'h0000_0077;
        push_pulse(2'd1, 1'b0, 4'd0);
        cmd(8'h01);
        tick(1);
        cmd(8'h00);
        tick(3);
        rd(A_STAT, 32'd6);
        chk("irq_err_case", {31'd0, IRQ}, 32'd1);
        wr(A_STAT, 32'd4, 4'hF);
        rd(A_STAT, 32'd2);
        rd(A_RES, 32'h0000_0077);
        rd(A_STAT, 32'd0);

        // Byte enables.
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_ADDR, 32'd0, 4'hF);
        wr(A_ADDR, 32'hFFFF_FFFF, 4'b0010); m_addr = 32'h0000_FF00;
        rd(A_ADDR, 32'h0000_FF00);
        wr(A_CMD, 32'd0, 4'b1110);
        tick(2);
        rd(A_STAT, 32'd0);
        wr(A_DATA, 32'h1122_3344, 4'b1001); m_data = 32'h11A5_0F44;
        rd(A_DATA, 32'h11A5_0F44);
        wr(A_CTRL, 32'hFFFF_FFFF, 4'hF);
        rd(A_CTRL, 32'd3);
        wr(A_CTRL, 32'd0, 4'hF);
        wr(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'h18, 32'd0);
        rd(BASE + 32'h1C, 32'd0);

        // Reset during WAIT aborts the command.
        model_val = 32'h5555_AAAA;
        push_pulse(2'd1, 1'b0, 4'd0);
        cmd(8'h01);
        tick(1);
        RES = 1'b1;
        @(posedge CLK);
        #1;
        RES = 1'b0;
        m_addr = 32'd0;
        m_data = 32'd0;
        chk_cim_idle("midrst");
        tick(4);
        rd(A_STAT, 32'd0);
        rd(A_RES, 32'd0);
        rd(A_ADDR, 32'd0);

        // Outside the window.
        rd_oow(32'h0000_2010);
        rd_oow(32'h0000_1020);
        wr(32'h0000_2004, 32'h0000_0055, 4'hF);
        rd(A_ADDR, 32'd0);

        tick(3);
        chk("pulse_q_empty", pulse_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
